// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU control unit.
// Walks every instruction through IF/ID/EXE/MEM/WB as its opcode requires and
// produces the datapath strobes for each step. A retired-instruction counter
// advances on every cycle that writes the PC.
//
// Timing notes:
//  - RegWre, mRD and mWR are registered. Each is computed from the next state,
//    so it is valid for the whole of the state it belongs to. The asynchronous
//    reset returns these three to their idle values at once, so an aborted
//    instruction cannot keep writing.
//  - The IR loads at the same edge that enters ID, so during ID the Op input
//    has only just become valid. For that reason PCWre, PCSrc and IRWre are
//    decoded combinationally from the current state. PCSrc also needs zero in
//    EXE without a cycle of delay, which is another reason it is combinational.
//  - Decodes that depend only on the opcode are combinational. They follow Op
//    in every state.
module multi_cycle_controller (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  Op,
    input  logic        zero,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        DBDataSrc,
    output logic        RegWre,
    output logic        mRD,
    output logic        mWR,
    output logic        RegDst,
    output logic        ExtSel,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUOp,
    output logic [2:0]  state,
    output logic [15:0] inst_count
);

    // Opcode map
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_BLTZ  = 6'b110010;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU function codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // PC source selections
    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] count_reg;
    logic        reg_wre_reg;
    logic        mrd_reg;
    logic        mwr_reg;

    // Opcode classes
    logic is_add, is_sub, is_addiu, is_andi, is_and, is_ori, is_or;
    logic is_sll, is_slti, is_sw, is_lw, is_beq, is_bne, is_bltz;
    logic is_j, is_halt;
    logic is_alu;       // register-writing ALU instruction (EXE then WB)
    logic is_mem;       // lw or sw (EXE then MEM)
    logic is_branch;    // conditional branch, finishes in EXE
    logic is_defined;

    logic pc_wre;
    logic branch_taken;
    logic [1:0] pc_src;

    // Per-opcode match lines
    always_comb begin
        is_add   = (Op == OP_ADD);
        is_sub   = (Op == OP_SUB);
        is_addiu = (Op == OP_ADDIU);
        is_andi  = (Op == OP_ANDI);
        is_and   = (Op == OP_AND);
        is_ori   = (Op == OP_ORI);
        is_or    = (Op == OP_OR);
        is_sll   = (Op == OP_SLL);
        is_slti  = (Op == OP_SLTI);
        is_sw    = (Op == OP_SW);
        is_lw    = (Op == OP_LW);
        is_beq   = (Op == OP_BEQ);
        is_bne   = (Op == OP_BNE);
        is_bltz  = (Op == OP_BLTZ);
        is_j     = (Op == OP_J);
        is_halt  = (Op == OP_HALT);

        is_alu     = is_add | is_sub | is_addiu | is_andi | is_and |
                     is_ori | is_or | is_sll | is_slti;
        is_mem     = is_sw | is_lw;
        is_branch  = is_beq | is_bne | is_bltz;
        is_defined = is_alu | is_mem | is_branch | is_j | is_halt;
    end

    // Opcode-only datapath selects; these follow Op in every state
    always_comb begin
        ALUSrcA   = is_sll;
        ALUSrcB   = is_addiu | is_andi | is_ori | is_slti | is_sw | is_lw;
        RegDst    = is_add | is_sub | is_and | is_or | is_sll;
        DBDataSrc = is_lw;
        ExtSel    = ~(is_andi | is_ori);
        InsMemRW  = 1'b1;

        ALUOp = ALU_ADD;
        if (is_sub | is_beq | is_bne)
            ALUOp = ALU_SUB;
        else if (is_sll)
            ALUOp = ALU_SLL;
        else if (is_ori | is_or)
            ALUOp = ALU_OR;
        else if (is_andi | is_and)
            ALUOp = ALU_AND;
        else if (is_slti | is_bltz)
            ALUOp = ALU_SLT;
    end

    // Next-state logic: each opcode class takes its own path back to IF
    always_comb begin
        state_next = S_IF;
        case (state_reg)
            S_IF:   state_next = S_ID;
            S_ID: begin
                if (is_halt)
                    state_next = S_HALT;
                else if (is_j || !is_defined)
                    state_next = S_IF;      // j and undefined ops finish here
                else
                    state_next = S_EXE;
            end
            S_EXE: begin
                if (is_branch)
                    state_next = S_IF;
                else if (is_mem)
                    state_next = S_MEM;
                else
                    state_next = S_WB;
            end
            S_MEM:  state_next = is_lw ? S_WB : S_IF;
            S_WB:   state_next = S_IF;
            S_HALT: state_next = S_HALT;    // only Reset leaves HALT
            default: state_next = S_IF;
        endcase
    end

    // PC write and PC source, asserted in the last state of each instruction
    always_comb begin
        branch_taken = (is_beq & zero) | ((is_bne | is_bltz) & ~zero);

        pc_wre = 1'b0;
        pc_src = PC_INC;
        case (state_reg)
            S_ID: begin
                if (is_j || !is_defined)
                    pc_wre = 1'b1;
                if (is_j)
                    pc_src = PC_JUMP;
            end
            S_EXE: begin
                if (is_branch) begin
                    pc_wre = 1'b1;
                    if (branch_taken)
                        pc_src = PC_BRANCH;
                end
            end
            S_MEM:  pc_wre = is_sw;
            S_WB:   pc_wre = 1'b1;
            default: begin
                pc_wre = 1'b0;
                pc_src = PC_INC;
            end
        endcase
    end

    // State register, retire counter and registered write strobes
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= S_IF;
            count_reg   <= 16'h0000;
            reg_wre_reg <= 1'b0;
            mrd_reg     <= 1'b1;
            mwr_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            if (pc_wre)
                count_reg <= count_reg + 16'h0001;
            reg_wre_reg <= (state_next == S_WB);
            mrd_reg     <= !((state_next == S_MEM) && is_lw);
            mwr_reg     <= !((state_next == S_MEM) && is_sw);
        end
    end

    // While in reset state_reg is IF, so the state-decoded strobes are idle too
    assign IRWre      = (state_reg == S_IF) && Reset;
    assign PCWre      = pc_wre;
    assign PCSrc      = pc_src;
    assign RegWre     = reg_wre_reg;
    assign mRD        = mrd_reg;
    assign mWR        = mwr_reg;
    assign state      = state_reg;
    assign inst_count = count_reg;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed testbench for multi_cycle_controller.
module tb_multi_cycle_controller;

    logic        CLK;
    logic        Reset;
    logic [5:0]  Op;
    logic        zero;
    logic        PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc;
    logic        RegWre, mRD, mWR, RegDst, ExtSel;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUOp;
    logic [2:0]  state;
    logic [15:0] inst_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    multi_cycle_controller dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
        .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .RegDst(RegDst),
        .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state),
        .inst_count(inst_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Checks one cycle's state and strobes; called at a falling edge
    task automatic expect_cycle(input string tag, input logic [2:0] st,
                                input logic pcw, input logic regw, input logic irw,
                                input logic mrd, input logic mwr, input logic [1:0] pcsrc);
        #1;
        check({tag, ".state"},  32'(state),  32'(st));
        check({tag, ".PCWre"},  32'(PCWre),  32'(pcw));
        check({tag, ".RegWre"}, 32'(RegWre), 32'(regw));
        check({tag, ".IRWre"},  32'(IRWre),  32'(irw));
        check({tag, ".mRD"},    32'(mRD),    32'(mrd));
        check({tag, ".mWR"},    32'(mWR),    32'(mwr));
        check({tag, ".PCSrc"},  32'(PCSrc),  32'(pcsrc));
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Decode table: {ALUOp, ALUSrcA, ALUSrcB, RegDst, DBDataSrc, ExtSel}
    logic [5:0] dec_op  [17];
    logic [7:0] dec_exp [17];

    initial begin
        dec_op[0]  = 6'b000000; dec_exp[0]  = {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        dec_op[1]  = 6'b000001; dec_exp[1]  = {3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        dec_op[2]  = 6'b000010; dec_exp[2]  = {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dec_op[3]  = 6'b010000; dec_exp[3]  = {3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        dec_op[4]  = 6'b010001; dec_exp[4]  = {3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        dec_op[5]  = 6'b010010; dec_exp[5]  = {3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        dec_op[6]  = 6'b010011; dec_exp[6]  = {3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        dec_op[7]  = 6'b011000; dec_exp[7]  = {3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        dec_op[8]  = 6'b011100; dec_exp[8]  = {3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dec_op[9]  = 6'b100110; dec_exp[9]  = {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dec_op[10] = 6'b100111; dec_exp[10] = {3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        dec_op[11] = 6'b110000; dec_exp[11] = {3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dec_op[12] = 6'b110001; dec_exp[12] = {3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dec_op[13] = 6'b110010; dec_exp[13] = {3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dec_op[14] = 6'b111000; dec_exp[14] = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dec_op[15] = 6'b111111; dec_exp[15] = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dec_op[16] = 6'b000011; dec_exp[16] = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    end

    initial begin
        Reset = 1'b0;
        Op    = 6'b000000;
        zero  = 1'b0;

        // Values held while in reset
        tick();
        expect_cycle("reset", 3'b000, 0, 0, 0, 1, 1, 2'b00);
        check("reset.inst_count", 32'(inst_count), 32'h0);
        check("InsMemRW", 32'(InsMemRW), 32'h1);
        Reset = 1'b1;

        // add: IF ID EXE WB
        Op = 6'b000000;
        expect_cycle("add.IF",  3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("add.ID",  3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("add.EXE", 3'b010, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("add.WB",  3'b100, 1, 1, 0, 1, 1, 2'b00);
        check("add.RegDst", 32'(RegDst), 32'h1); tick();
        exp_count = 1;
        check("add.inst_count", 32'(inst_count), 32'(exp_count));

        // lw: IF ID EXE MEM WB
        Op = 6'b100111;
        expect_cycle("lw.IF",  3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("lw.ID",  3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("lw.EXE", 3'b010, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("lw.MEM", 3'b011, 0, 0, 0, 0, 1, 2'b00); tick();
        expect_cycle("lw.WB",  3'b100, 1, 1, 0, 1, 1, 2'b00);
        check("lw.DBDataSrc", 32'(DBDataSrc), 32'h1); tick();
        exp_count = 2;

        // sw: IF ID EXE MEM
        Op = 6'b100110;
        expect_cycle("sw.IF",  3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("sw.ID",  3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("sw.EXE", 3'b010, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("sw.MEM", 3'b011, 1, 0, 0, 1, 0, 2'b00); tick();
        exp_count = 3;
        check("sw.inst_count", 32'(inst_count), 32'(exp_count));

        // beq taken (zero=1)
        Op = 6'b110000; zero = 1'b1;
        expect_cycle("beq.IF",  3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("beq.ID",  3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("beq.EXE", 3'b010, 1, 0, 0, 1, 1, 2'b01); tick();

        // bne not taken (zero=1)
        Op = 6'b110001; zero = 1'b1;
        expect_cycle("bne.IF",  3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("bne.ID",  3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("bne.EXE", 3'b010, 1, 0, 0, 1, 1, 2'b00); tick();

        // bltz taken (zero=0)
        Op = 6'b110010; zero = 1'b0;
        expect_cycle("bltz.IF",  3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("bltz.ID",  3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("bltz.EXE", 3'b010, 1, 0, 0, 1, 1, 2'b01); tick();
        exp_count = 6;
        check("branch.inst_count", 32'(inst_count), 32'(exp_count));

        // undefined opcode: IF ID, retired as a nop
        Op = 6'b000011;
        expect_cycle("undef.IF", 3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("undef.ID", 3'b001, 1, 0, 0, 1, 1, 2'b00); tick();
        exp_count = 7;
        check("undef.inst_count", 32'(inst_count), 32'(exp_count));

        // Counter wrap: preload 0xFFFF, then retire a j
        force dut.count_reg = 16'hFFFF;
        #1;
        release dut.count_reg;
        check("wrap.preload", 32'(inst_count), 32'hFFFF);
        Op = 6'b111000;
        expect_cycle("jw.IF", 3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("jw.ID", 3'b001, 1, 0, 0, 1, 1, 2'b10); tick();
        check("wrap.inst_count", 32'(inst_count), 32'h0000);

        // Reset pulsed during the MEM state of sw
        Op = 6'b100110;
        expect_cycle("swr.IF",  3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("swr.ID",  3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("swr.EXE", 3'b010, 0, 0, 0, 1, 1, 2'b00); tick();
        expect_cycle("swr.MEM", 3'b011, 1, 0, 0, 1, 0, 2'b00);
        #1 Reset = 1'b0;
        expect_cycle("swr.abort", 3'b000, 0, 0, 0, 1, 1, 2'b00);
        check("swr.inst_count", 32'(inst_count), 32'h0);
        tick();
        expect_cycle("swr.held", 3'b000, 0, 0, 0, 1, 1, 2'b00);
        Reset = 1'b1;
        exp_count = 0;

        // j then halt
        Op = 6'b111000;
        expect_cycle("j.IF", 3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("j.ID", 3'b001, 1, 0, 0, 1, 1, 2'b10); tick();
        exp_count = 1;
        Op = 6'b111111;
        expect_cycle("halt.IF", 3'b000, 0, 0, 1, 1, 1, 2'b00); tick();
        expect_cycle("halt.ID", 3'b001, 0, 0, 0, 1, 1, 2'b00); tick();
        for (int i = 0; i < 10; i++) begin
            expect_cycle($sformatf("halt.%0d", i), 3'b111, 0, 0, 0, 1, 1, 2'b00);
            check($sformatf("halt.%0d.inst_count", i), 32'(inst_count), 32'(exp_count));
            tick();
        end

        // Opcode-only decodes, exercised while parked in HALT
        for (int i = 0; i < 17; i++) begin
            Op = dec_op[i];
            #1;
            check($sformatf("dec.%06b", dec_op[i]),
                  32'({ALUOp, ALUSrcA, ALUSrcB, RegDst, DBDataSrc, ExtSel}),
                  32'(dec_exp[i]));
        end
        tick();
        check("halt.final_state", 32'(state), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is CLK; the reset is Reset, asynchronous and active-low.
REQ-002 Port list (name  direction  width  meaning):
 - CLK  in  1  rising-edge clock
 - Reset  in  1  async active-low reset
 - Op  in  6  opcode from instruction register, stable from ID onward
 - zero  in  1  ALU zero/compare flag
 - PCWre  out  1  PC write enable
 - IRWre  out  1  instruction register load
 - InsMemRW  out  1  instruction memory read (constant 1)
 - ALUSrcA  out  1  1 = shift amount on ALU A
 - ALUSrcB  out  1  1 = extended immediate on ALU B
 - DBDataSrc  out  1  1 = data memory to register write bus
 - RegWre  out  1  register file write enable
 - mRD  out  1  data memory read, active-low
 - mWR  out  1  data memory write, active-low
 - RegDst  out  1  1 = rd, 0 = rt destination
 - ExtSel  out  1  0 = zero-extend, 1 = sign-extend
 - PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
 - ALUOp  out  3  ALU function code
 - state  out  3  current state, for debug
 - inst_count  out  16  retired-instruction counter
REQ-003 The opcodes SHALL be: add 000000, sub 000001, addiu 000010, andi 010000, and 010001, ori 010010, or 010011, sll 011000, slti 011100, sw 100110, lw 100111, beq 110000, bne 110001, bltz 110010, j 111000, halt 111111; all others are undefined.

Function
REQ-004 The state encoding SHALL be IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111, with one state register updated on CLK rising edge.
REQ-005 The state sequences SHALL be: ALU ops IF-ID-EXE-WB-IF; sw IF-ID-EXE-MEM-IF; lw IF-ID-EXE-MEM-WB-IF; beq/bne/bltz IF-ID-EXE-IF; j IF-ID-IF; halt IF-ID-HALT; undefined opcode IF-ID-IF, treated as a nop.
REQ-006 HALT SHALL be absorbing until Reset is asserted.
REQ-007 IRWre SHALL be 1 only in IF.
REQ-008 PCWre SHALL be 1 only in the final state of each instruction: WB, the sw MEM state, the branch EXE state, and the j/undefined ID state; it SHALL be 0 in HALT.
REQ-009 RegWre SHALL be 1 only in WB.
REQ-010 In MEM, mRD SHALL be 0 only for lw and mWR SHALL be 0 only for sw; both SHALL be 1 elsewhere.
REQ-011 PCSrc SHALL be:
 - 10 in ID for j;
 - in EXE: 01 when beq and zero=1, 01 when bne or bltz and zero=0, otherwise 00;
 - 00 in all other states.
 zero is used combinationally and only in EXE.
REQ-012 ALUOp SHALL be, per opcode in every state: add/addiu/sw/lw 000, sub/beq/bne 001, sll 010, ori/or 011, andi/and 100, slti/bltz 110, all others 000.
REQ-013 The opcode-only decodes SHALL be:
 - ALUSrcB=1 for addiu/andi/ori/slti/sw/lw;
 - ALUSrcA=1 for sll;
 - RegDst=1 for add/sub/and/or/sll;
 - DBDataSrc=1 for lw;
 - ExtSel=0 for andi/ori, 1 otherwise.
REQ-014 inst_count SHALL increment by 1, wrapping 0xFFFF to 0x0000, on every edge where PCWre=1.

Reset
REQ-015 While Reset=0, the block SHALL force: state=IF, inst_count=0, PCWre=0, RegWre=0, IRWre=0, mRD=1, mWR=1, PCSrc=00.
REQ-016 Reset asserted mid-instruction SHALL abort the instruction immediately, with no write enable asserted afterward.
REQ-017 After Reset deasserts, the first rising edge SHALL be an IF cycle.

Verification
REQ-018 add (000000) after reset -> states 000,001,010,100,000; RegWre=1, RegDst=1, PCWre=1 only in WB; inst_count=1.
REQ-019 lw then sw -> lw takes 5 cycles with mRD=0 in MEM and DBDataSrc=1; sw takes 4 cycles with mWR=0 in MEM and RegWre never 1; inst_count=2.
REQ-020 beq with zero=1, then bne with zero=1 -> PCSrc=01 in the first EXE, 00 in the second; each takes 3 cycles.
REQ-021 j followed by halt -> PCSrc=10 and PCWre=1 in the j ID; state stays 111 for 10 cycles with PCWre=0 and inst_count unchanged.
REQ-022 Reset=0 pulsed during the MEM state of sw -> mWR returns to 1 immediately, state=000, inst_count=0.
REQ-023 Preload inst_count=0xFFFF by forcing, then retire one instruction -> inst_count=0x0000.
